led_mode_selector: RTL and testbench

Downstream consumer of the five free-running blink toggles produced by the sequential blinker stage. It debounces a raw push-button and advances a 7-mode selector on each press. It then drives five registered LED outputs: direct pass-through, all LEDs mirroring one blink rate, or a one-hot chaser stepped by the slowest blink source. All logic runs in the blinker's clock domain.

---
 rtl/led_mode_selector.sv | 135 +++++++++++++
 tb/tb_led_mode_selector.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_selector.sv
// led_mode_selector: debounced push-button steps a 7-mode selector that picks
// how the five upstream blink toggles are shown on the LEDs (pass-through,
// one blink rate mirrored on all LEDs, or a one-hot chaser stepped by blink0).
module led_mode_selector #(
    parameter int unsigned DEBOUNCE_CLKS = 250000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [4:0] i_blink,
    input  logic       i_button,
    output logic [4:0] o_led,
    output logic [2:0] o_mode,
    output logic       o_press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CLKS);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CLKS - 1);

    typedef enum logic [2:0] {
        MODE_0 = 3'd0,
        MODE_1 = 3'd1,
        MODE_2 = 3'd2,
        MODE_3 = 3'd3,
        MODE_4 = 3'd4,
        MODE_5 = 3'd5,
        MODE_6 = 3'd6
    } mode_t;

    logic [1:0]    sync_ff;
    logic          sync;
    logic          db;
    logic          db_q;
    logic [CW-1:0] cnt;
    logic          blink0_q;
    logic [4:0]    chaser;
    mode_t         state;
    mode_t         next_mode;
    logic          press_edge;
    logic          blink0_rise;

    assign sync        = sync_ff[1];
    assign press_edge  = db & ~db_q;
    assign blink0_rise = i_blink[0] & ~blink0_q;
    assign o_mode      = state;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[0], i_button};
        end
    end

    // Debounce: the state flips only after DEBOUNCE_CLKS consecutive differing samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            db   <= 1'b0;
            db_q <= 1'b0;
            cnt  <= '0;
        end else begin
            db_q <= db;
            if (sync == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db  <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Successor of the current mode, wrapping 6 back to 0.
    always_comb begin
        next_mode = MODE_0;
        case (state)
            MODE_0:  next_mode = MODE_1;
            MODE_1:  next_mode = MODE_2;
            MODE_2:  next_mode = MODE_3;
            MODE_3:  next_mode = MODE_4;
            MODE_4:  next_mode = MODE_5;
            MODE_5:  next_mode = MODE_6;
            default: next_mode = MODE_0;
        endcase
    end

    // Mode FSM with the registered press pulse; both change on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= MODE_0;
            o_press <= 1'b0;
        end else begin
            o_press <= press_edge;
            if (press_edge) begin
                state <= next_mode;
            end
        end
    end

    // Chaser: restart on entry to mode 6 (wins over a coincident blink0 rise),
    // otherwise rotate left on each blink0 rising edge while in mode 6.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink0_q <= 1'b0;
            chaser   <= 5'b00001;
        end else begin
            blink0_q <= i_blink[0];
            if (press_edge && next_mode == MODE_6) begin
                chaser <= 5'b00001;
            end else if (state == MODE_6 && blink0_rise) begin
                chaser <= {chaser[3:0], chaser[4]};
            end
        end
    end

    // Registered LED mapping from the current mode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_led <= '0;
        end else begin
            case (state)
                MODE_0:  o_led <= i_blink;
                MODE_1:  o_led <= {5{i_blink[0]}};
                MODE_2:  o_led <= {5{i_blink[1]}};
                MODE_3:  o_led <= {5{i_blink[2]}};
                MODE_4:  o_led <= {5{i_blink[3]}};
                MODE_5:  o_led <= {5{i_blink[4]}};
                MODE_6:  o_led <= chaser;
                default: o_led <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_led_mode_selector.sv
// Self-checking bench for led_mode_selector with DEBOUNCE_CLKS = 4.
module tb_led_mode_selector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] blink = '0;
    logic       button = 1'b0;
    logic [4:0] led;
    logic [2:0] mode;
    logic       press;

    int n_cmp = 0;
    int n_err = 0;
    int cur_mode = 0;

    typedef struct {
        int         mode;
        logic [4:0] blink;
        logic [4:0] led;
    } vec_t;

    vec_t tbl [12];

    led_mode_selector #(.DEBOUNCE_CLKS(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_blink (blink),
        .i_button(button),
        .o_led   (led),
        .o_mode  (mode),
        .o_press (press)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        button = 1'b0;
        blink  = '0;
        tick();
        tick();
        rst_n    = 1'b1;
        cur_mode = 0;
    endtask

    // Press and release with margin; expect exactly one pulse and the new mode.
    task automatic press_once(input int exp_mode, output int pulses);
        pulses = 0;
        button = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (press) pulses++;
        end
        button = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (press) pulses++;
        end
        chk("press_pulses", 8'(pulses), 8'd1);
        chk("press_mode", {5'b0, mode}, 8'(exp_mode));
    endtask

    // One blink0 rising edge, then one more edge for the LED register.
    task automatic blink0_rise(input logic [4:0] exp_led);
        blink[0] = 1'b0;
        tick();
        blink[0] = 1'b1;
        tick();
        tick();
        chk("chaser_step", {3'b0, led}, {3'b0, exp_led});
    endtask

    initial begin
        int pulses;
        int total;

        tbl[0]  = '{0, 5'b10101, 5'b10101};
        tbl[1]  = '{0, 5'b01010, 5'b01010};
        tbl[2]  = '{1, 5'b00001, 5'b11111};
        tbl[3]  = '{1, 5'b11110, 5'b00000};
        tbl[4]  = '{2, 5'b00010, 5'b11111};
        tbl[5]  = '{2, 5'b11101, 5'b00000};
        tbl[6]  = '{3, 5'b00100, 5'b11111};
        tbl[7]  = '{3, 5'b11011, 5'b00000};
        tbl[8]  = '{4, 5'b01000, 5'b11111};
        tbl[9]  = '{4, 5'b10111, 5'b00000};
        tbl[10] = '{5, 5'b10000, 5'b11111};
        tbl[11] = '{5, 5'b01111, 5'b00000};

        // Reset values while held, then pass-through one edge after release.
        rst_n = 1'b0;
        blink = 5'b10101;
        tick();
        tick();
        chk("rst_led", {3'b0, led}, 8'd0);
        chk("rst_mode", {5'b0, mode}, 8'd0);
        chk("rst_press", {7'b0, press}, 8'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_release_led", {3'b0, led}, 8'b00010101);

        // Clean press: pulse only at edge 7.
        button = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("clean_press_e%0d", k), {7'b0, press}, (k == 7) ? 8'd1 : 8'd0);
            if (k == 7) chk("clean_mode", {5'b0, mode}, 8'd1);
        end
        blink = 5'b00001;
        tick();
        chk("clean_led", {3'b0, led}, 8'b00011111);
        button = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (press) pulses++;
        end
        chk("release_no_pulse", 8'(pulses), 8'd0);

        // Bounce rejection.
        do_reset();
        pulses = 0;
        for (int r = 0; r < 5; r++) begin
            button = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (press) pulses++;
            end
            button = 1'b0;
            for (int k = 0; k < 2; k++) begin
                tick();
                if (press) pulses++;
            end
        end
        chk("bounce_pulses", 8'(pulses), 8'd0);
        chk("bounce_mode", {5'b0, mode}, 8'd0);
        button = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("bounce_hold_e%0d", k), {7'b0, press}, (k == 7) ? 8'd1 : 8'd0);
        end
        chk("bounce_hold_mode", {5'b0, mode}, 8'd1);

        // Wrap through all seven modes.
        do_reset();
        total = 0;
        for (int p = 1; p <= 7; p++) begin
            press_once(p % 7, pulses);
            total += pulses;
        end
        chk("wrap_total", 8'(total), 8'd7);

        // Mapping table for modes 0..5.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            while (cur_mode < tbl[i].mode) begin
                cur_mode++;
                press_once(cur_mode, pulses);
            end
            blink = tbl[i].blink;
            tick();
            chk($sformatf("map_%0d", i), {3'b0, led}, {3'b0, tbl[i].led});
        end

        // Chaser: enter mode 6 on the same edge blink0 rises.
        blink  = 5'b00000;
        tick();
        button = 1'b1;
        for (int k = 1; k <= 6; k++) tick();
        blink = 5'b00001;
        tick();
        chk("chaser_enter_press", {7'b0, press}, 8'd1);
        chk("chaser_enter_mode", {5'b0, mode}, 8'd6);
        tick();
        chk("chaser_load", {3'b0, led}, 8'b00000001);
        blink0_rise(5'b00010);
        blink0_rise(5'b00100);
        blink0_rise(5'b01000);
        blink0_rise(5'b10000);
        blink0_rise(5'b00001);
        blink0_rise(5'b00010);
        button = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("chaser_exit_mode", {5'b0, mode}, 8'd6);

        // Reset mid-debounce, released with the button still held.
        do_reset();
        button = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mode", {5'b0, mode}, 8'd0);
        chk("mid_rst_led", {3'b0, led}, 8'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("mid_rst_press_e%0d", k), {7'b0, press}, (k == 7) ? 8'd1 : 8'd0);
            if (k == 7) chk("mid_rst_mode_after", {5'b0, mode}, 8'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
